// File: rtl/dlfloat_mac_feeder.sv
// dlfloat_mac_feeder: FIFO-buffered sequencer that turns a free-running DLfloat16 MAC into a dot-product engine
module dlfloat_mac_feeder #(
  parameter int DEPTH   = 16,
  parameter int LEN_W   = 8,
  parameter int MAC_LAT = 4,
  parameter int CLR_CYC = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  output logic [15:0]      mac_a,
  output logic [15:0]      mac_b,
  output logic             mac_rst_n,
  input  logic [15:0]      mac_c,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [15:0]      res_data,
  output logic             busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2((CLR_CYC > MAC_LAT ? CLR_CYC : MAC_LAT) + 1);
  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [31:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [15:0] mac_a_q, mac_a_d, mac_b_q, mac_b_d, res_data_q, res_data_d;
  logic mac_rst_n_q, mac_rst_n_d, res_valid_q, res_valid_d, busy_q, busy_d;
  logic push, pop;
  assign in_ready  = count_q != CW'(DEPTH);
  assign cmd_ready = state_q == IDLE;
  assign push      = in_valid && in_ready;
  assign pop       = state_q == FEED && count_q != '0;
  assign mac_a     = mac_a_q;
  assign mac_b     = mac_b_q;
  assign mac_rst_n = mac_rst_n_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign busy      = busy_q;
  always_ff @(posedge clk)
    if (push) mem_q[wr_ptr_q] <= {in_a, in_b};
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    mac_a_d     = '0;
    mac_b_d     = '0;
    mac_rst_n_d = 1'b1;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d    = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d     = count_q + CW'(push) - CW'(pop);
    case (state_q)
      IDLE:
        if (cmd_valid) begin
          rem_d   = cmd_len;
          cnt_d   = '0;
          state_d = CLEAR;
        end
      CLEAR: begin
        mac_rst_n_d = 1'b0;
        cnt_d       = cnt_q + 1'b1;
        if (cnt_q == TW'(CLR_CYC - 1)) begin
          cnt_d   = '0;
          state_d = rem_q == '0 ? DRAIN : FEED;
        end
      end
      FEED:
        if (pop) begin
          {mac_a_d, mac_b_d} = mem_q[rd_ptr_q];
          rem_d              = rem_q - 1'b1;
          state_d            = rem_q == LEN_W'(1) ? DRAIN : FEED;
        end
      DRAIN: begin
        cnt_d = cnt_q + 1'b1;
        // last operand pair has settled into the accumulator by now
        if (cnt_q == TW'(MAC_LAT - 1)) begin
          res_data_d  = mac_c;
          res_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE:
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      mac_a_q     <= '0;
      mac_b_q     <= '0;
      mac_rst_n_q <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      mac_a_q     <= mac_a_d;
      mac_b_q     <= mac_b_d;
      mac_rst_n_q <= mac_rst_n_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      busy_q      <= busy_d;
    end
endmodule

// File: tb/tb_dlfloat_mac_feeder.sv
// tb_dlfloat_mac_feeder: randomized scoreboard bench with a behavioural DLfloat16 MAC attached
module tb_dlfloat_mac_feeder;
  localparam int DEPTH = 16, LEN_W = 8, MAC_LAT = 4, CLR_CYC = 3;
  logic clk = 0, rst = 0;
  logic in_valid = 0, in_ready, cmd_valid = 0, cmd_ready, res_valid, res_ready = 1, busy, mac_rst_n;
  logic [15:0] in_a = 0, in_b = 0, mac_a, mac_b, mac_c, res_data;
  logic [LEN_W-1:0] cmd_len = 0;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  dlfloat_mac_feeder #(.DEPTH(DEPTH), .LEN_W(LEN_W), .MAC_LAT(MAC_LAT), .CLR_CYC(CLR_CYC)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len), .mac_a(mac_a), .mac_b(mac_b),
    .mac_rst_n(mac_rst_n), .mac_c(mac_c), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .busy(busy));
  function automatic real d2r(input logic [15:0] x);
    real v;
    int e;
    if (x[14:9] == 6'd0) return 0.0;
    v = 1.0 + real'(x[8:0]) / 512.0;
    e = int'(x[14:9]) - 31;
    for (int i = 0; i < e; i++) v = v * 2.0;
    for (int i = 0; i > e; i--) v = v / 2.0;
    return x[15] ? -v : v;
  endfunction
  function automatic logic [15:0] r2d(input real v);
    logic s;
    real a;
    int e;
    if (v == 0.0) return 16'h0000;
    s = v < 0.0;
    a = s ? -v : v;
    e = 31;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0) begin a = a * 2.0; e--; end
    return {s, 6'(e), 9'(int'((a - 1.0) * 512.0))};
  endfunction
  function automatic logic [15:0] rv();
    logic [15:0] t [8] = '{16'h3E00, 16'h4000, 16'h4100, 16'h3C00, 16'hBE00, 16'h4200, 16'h0000, 16'hC000};
    return t[$urandom_range(0, 7)];
  endfunction
  // external MAC: contribution visible on mac_c three edges after the pair appears
  real p0 = 0.0, p1 = 0.0, acc = 0.0;
  always @(posedge clk)
    if (!mac_rst_n) begin
      p0 <= 0.0; p1 <= 0.0; acc <= 0.0;
    end else begin
      p0 <= d2r(mac_a) * d2r(mac_b); p1 <= p0; acc <= acc + p1;
    end
  assign mac_c = r2d(acc);
  logic [31:0] mq [$];
  logic [15:0] expq [$];
  int pend_len = -1;
  real msum;
  logic [31:0] mp;
  logic [15:0] me;
  always @(negedge clk)
    if (rst) begin
      mq.delete(); expq.delete(); pend_len = -1;
    end else begin
      if (in_valid && in_ready) mq.push_back({in_a, in_b});
      if (cmd_valid && cmd_ready) pend_len = int'(cmd_len);
      if (pend_len >= 0 && mq.size() >= pend_len) begin
        msum = 0.0;
        for (int i = 0; i < pend_len; i++) begin
          mp = mq.pop_front();
          msum = msum + d2r(mp[31:16]) * d2r(mp[15:0]);
        end
        expq.push_back(r2d(msum));
        pend_len = -1;
      end
      if (res_valid && res_ready) begin
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL result: got %h with no result expected", res_data);
        end else begin
          me = expq.pop_front();
          if (res_data !== me) begin
            errors++;
            $display("FAIL result: got %h expected %h", res_data, me);
          end
        end
      end
    end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic push(input logic [15:0] a, input logic [15:0] b);
    int n = 0;
    in_a = a; in_b = b; in_valid = 1;
    @(negedge clk);
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (!in_ready) chk("push timeout", 0, 1);
    tick();
    in_valid = 0;
  endtask
  task automatic cmd(input int len);
    int n = 0;
    cmd_len = LEN_W'(len); cmd_valid = 1;
    @(negedge clk);
    while (!cmd_ready && n < 300) begin @(negedge clk); n++; end
    if (!cmd_ready) chk("cmd timeout", 0, 1);
    tick();
    cmd_valid = 0;
  endtask
  task automatic wait_res(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!res_valid && n < 300);
    if (!res_valid) chk("result timeout", 0, 1);
  endtask
  initial begin
    int n, occ;
    #1 rst = 1;
    repeat (2) @(negedge clk);
    chk("rst mac_a", mac_a, 0);
    chk("rst mac_b", mac_b, 0);
    chk("rst mac_rst_n", mac_rst_n, 0);
    chk("rst res_valid", res_valid, 0);
    chk("rst res_data", res_data, 0);
    chk("rst busy", busy, 0);
    chk("rst in_ready", in_ready, 1);
    chk("rst cmd_ready", cmd_ready, 1);
    tick(); rst = 0;
    tick();
    chk("mac_rst_n after release", mac_rst_n, 1);
    push(16'h3E00, 16'h4000); push(16'h3E00, 16'h3E00);
    cmd(2); wait_res(n);
    chk("dot2 latency", n, 1 + CLR_CYC + 2 + MAC_LAT);
    chk("dot2 value", res_data, 16'h4100);
    tick();
    push(16'h4000, 16'h4000);
    cmd(1); wait_res(n);
    chk("clear between cmds", res_data, 16'h4200);
    tick();
    cmd(0); wait_res(n);
    chk("len0 latency", n, 1 + CLR_CYC + MAC_LAT);
    chk("len0 value", res_data, 16'h0000);
    tick();
    chk("len0 fifo untouched", in_ready, 1);
    cmd(2);
    repeat (6) tick();
    chk("stall mac_a", mac_a, 0);
    chk("stall mac_b", mac_b, 0);
    chk("stall busy", busy, 1);
    push(16'h3E00, 16'h3E00);
    repeat (5) tick();
    push(16'h3E00, 16'h3E00);
    wait_res(n);
    chk("stall value", res_data, 16'h4000);
    tick();
    for (int i = 0; i < DEPTH; i++) push(rv(), rv());
    @(negedge clk);
    chk("full in_ready", in_ready, 0);
    in_a = 16'h4200; in_b = 16'h4200; in_valid = 1;
    tick();
    in_valid = 0;
    cmd(3); wait_res(n); tick();
    chk("in_ready after 3 pops", in_ready, 1);
    cmd(13); wait_res(n); tick();
    cmd(1); push(16'h4000, 16'h4100); wait_res(n);
    chk("17th push dropped", res_data, 16'h4300);
    tick();
    push(16'h3E00, 16'h4000);
    res_ready = 0;
    cmd(1); wait_res(n);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("hold res_valid", res_valid, 1);
      chk("hold res_data", res_data, 16'h4000);
      chk("hold cmd_ready", cmd_ready, 0);
    end
    tick(); res_ready = 1;
    tick(); tick();
    chk("released res_valid", res_valid, 0);
    for (int i = 0; i < 4; i++) push(16'h4000, 16'h4000);
    cmd(4);
    repeat (4) tick();
    #2 rst = 1;
    #1;
    chk("midrst mac_a", mac_a, 0);
    chk("midrst mac_rst_n", mac_rst_n, 0);
    chk("midrst res_valid", res_valid, 0);
    chk("midrst busy", busy, 0);
    chk("midrst in_ready", in_ready, 1);
    chk("midrst cmd_ready", cmd_ready, 1);
    @(negedge clk);
    tick(); rst = 0;
    tick();
    chk("midrst mac_rst_n release", mac_rst_n, 1);
    cmd(1); push(16'h3E00, 16'h4200); wait_res(n);
    chk("after midrst", res_data, 16'h4200);
    tick();
    occ = 0; res_ready = 0;
    for (int it = 0; it < 20; it++) begin
      int k, len;
      k = $urandom_range(0, 3);
      if (occ + k > DEPTH) k = DEPTH - occ;
      for (int j = 0; j < k; j++) push(rv(), rv());
      occ += k;
      len = $urandom_range(0, occ + 2);
      cmd(len);
      if (len > occ) begin
        for (int j = 0; j < len - occ; j++) begin
          repeat ($urandom_range(0, 2)) tick();
          push(rv(), rv());
        end
        occ = 0;
      end else occ -= len;
      wait_res(n);
      repeat ($urandom_range(0, 3)) tick();
      res_ready = 1; tick(); res_ready = 0;
    end
    repeat (3) tick();
    chk("scoreboard drained", expq.size(), 0);
    chk("final busy", busy, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/dlfloat_mac_feeder.md
Name: dlfloat_mac_feeder

Overview:
- Sequencer on the driving side of dlfloat_mac.
- Buffers DLfloat16 operand pairs (1 sign, 6 exponent, 9 mantissa, bias 31) in an internal FIFO.
- On a length command, it clears the MAC accumulator, streams exactly N pairs into mac_a/mac_b, waits out the MAC pipeline, then returns the dot product over a valid/ready result port.
- Turns the free-running MAC into a transaction-level dot-product engine.

Parameters:
DEPTH, 16, operand FIFO entries (power of two, >=2)
LEN_W, 8, width of cmd_len
MAC_LAT, 4, cycles from a pair on mac_a/mac_b to its contribution settled on mac_c
CLR_CYC, 3, cycles mac_rst_n is held low to zero the MAC accumulator

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  operand pair offered
in_ready  out  1  FIFO not full
in_a  in  16  DLfloat16 operand A
in_b  in  16  DLfloat16 operand B
cmd_valid  in  1  dot-product command offered
cmd_ready  out  1  high only in IDLE
cmd_len  in  LEN_W  number of pairs to accumulate
mac_a  out  16  registered operand to MAC
mac_b  out  16  registered operand to MAC
mac_rst_n  out  1  active-low MAC reset/clear
mac_c  in  16  MAC accumulator output
res_valid  out  1  result available
res_ready  in  1  result accepted
res_data  out  16  captured dot product
busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst=1) values:
  - state=IDLE; FIFO flushed (rd/wr ptr=0, count=0).
  - mac_a=mac_b=0, mac_rst_n=0.
  - res_valid=0, res_data=0, busy=0.
  - Reset mid-operation abandons the transaction; no partial result is emitted.
- First cycle after reset release: mac_rst_n=1.
- All outputs are registered, except in_ready=(count!=DEPTH) and cmd_ready=(state==IDLE).
- FIFO:
  - Push on in_valid&in_ready; pop is internal (FEED only).
  - Push is refused when full, even if a pop occurs the same cycle.
  - Push and pop in the same cycle when not full leaves count unchanged.
  - Pointers wrap modulo DEPTH; count is clog2(DEPTH)+1 bits.
- IDLE:
  - mac_a=mac_b=0, mac_rst_n=1.
  - On cmd_valid: latch cmd_len into remaining, clear clear/drain counter, go CLEAR.
- CLEAR:
  - mac_rst_n=0, operands=0, for exactly CLR_CYC cycles.
  - Then: if remaining==0 go DRAIN, else go FEED.
- FEED:
  - Each cycle with FIFO non-empty: pop, drive pair on mac_a/mac_b next edge, remaining-1.
  - FIFO empty: stall, drive 0/0 (adds +0), remaining unchanged.
  - Pop of the last pair (remaining==1) goes to DRAIN.
  - Exactly cmd_len pairs are consumed. Pairs beyond the count stay in the FIFO for the next command.
- DRAIN:
  - Operands=0 for MAC_LAT cycles, then capture mac_c into res_data, set res_valid=1, go DONE.
- DONE:
  - Hold res_data/res_valid until res_valid&res_ready, then res_valid=0, go IDLE.
  - cmd_ready=0 throughout, so a new command cannot overwrite an unread result.
- Latency with a pre-filled FIFO: command accept to res_valid = 1 + CLR_CYC + cmd_len + MAC_LAT cycles.
- No arithmetic in this block. Values pass bit-exact; rounding and special cases belong to the MAC.
- MAC contract: while mac_rst_n=0, the MAC accumulator reads 0 by the end of CLR_CYC cycles.

Test Plan:
- Push (0x3E00,0x4000) and (0x3E00,0x3E00), i.e. 1*2 and 1*1; cmd_len=2 -> res_data=0x4100 (3.0); res_valid exactly 1+3+2+4=10 cycles after cmd accept.
- Back-to-back: after the above, push (0x4000,0x4000) and issue cmd_len=1 -> res_data=0x4200 (4.0), not 7.0. Proves CLEAR zeroes the accumulator.
- cmd_len=0 with empty FIFO -> res_data=0x0000 after 1+3+4 cycles; FIFO untouched.
- Command before data; two pairs of 1*1 pushed 5 cycles apart -> FEED stalls with 0/0 operands; res_data=0x4000 (2.0).
- Push 16 pairs with no command -> in_ready=0 at count 16; 17th push ignored. Then cmd_len=3 -> 13 entries remain.
- Hold res_ready=0 for 20 cycles -> res_valid and res_data stable, cmd_ready=0. Assert rst mid-FEED -> all outputs at reset values, FIFO empty, next command completes normally.
